// File: rtl/moving_avg_filter.sv
// Boxcar averager for ADC sample streams: a conditioning register, then a running-sum
// accumulate stage that updates the average and pulses out_valid once per accepted sample.
module moving_avg_filter #(
  parameter int DATA_W      = 12,
  parameter int LOG2_DEPTH  = 3,
  parameter int SIGNED_MODE = 0,
  parameter int ROUND       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int SW    = DATA_W + LOG2_DEPTH;
  localparam int XW    = SW + 1;
  localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int HIST  = 2 ** PTR_W;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [XW-1:0] RND  = (ROUND != 0) ? XW'(DEPTH / 2) : '0;
  localparam logic [XW-1:0] MAXP = XW'({1'b0, {(DATA_W - 1){1'b1}}});

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [DATA_W-1:0] hist_q [HIST];
  logic [SW-1:0]     sum_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic [DATA_W-1:0] cond_data;
  logic [DATA_W-1:0] oldest;
  logic [XW-1:0]     sum_x;
  logic [XW-1:0]     rounded;
  logic [XW-1:0]     shifted;
  logic              over;
  logic [SW-1:0]     sum_d;
  logic [PTR_W-1:0]  ptr_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] out_data_d;

  // Widen a sample to the extended sum width, sign-extending only in signed mode.
  function automatic logic [XW-1:0] ext_sample(input logic [DATA_W-1:0] x);
    logic s;
    s = (SIGNED_MODE != 0) && x[DATA_W-1];
    return {{(XW - DATA_W){s}}, x};
  endfunction

  always_comb begin
    cond_data = in_data;
    if (SIGNED_MODE == 0 && in_data[DATA_W-1]) cond_data = '0;

    oldest  = hist_q[ptr_q];
    sum_x   = {((SIGNED_MODE != 0) && sum_q[SW-1]), sum_q}
              + ext_sample(s1_data_q) - ext_sample(oldest);
    sum_d   = sum_x[SW-1:0];
    rounded = sum_x + RND;

    if (SIGNED_MODE != 0) begin
      shifted = $unsigned($signed(rounded) >>> LOG2_DEPTH);
      over    = $signed(shifted) > $signed(MAXP);
    end else begin
      shifted = rounded >> LOG2_DEPTH;
      over    = shifted > MAXP;
    end
    out_data_d = over ? MAXP[DATA_W-1:0] : shifted[DATA_W-1:0];

    ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    cnt_d = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      sum_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
    end else if (clr) begin
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      if (in_valid) s1_data_q <= cond_data;
      if (s1_valid_q) begin
        sum_q         <= sum_d;
        hist_q[ptr_q] <= s1_data_q;
        ptr_q         <= ptr_d;
        cnt_q         <= cnt_d;
        out_data_q    <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_moving_avg_filter.sv
// Bench for moving_avg_filter: five configurations share one stimulus stream and are
// checked each cycle against a window-queue model plus directed values.
module tb_moving_avg_filter;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid;
  logic [11:0] in_data;
  logic [N-1:0] ov, pr;
  logic [11:0] od [N];

  int n_cmp = 0;
  int n_err = 0;

  int win [N][$];
  int cnt [N];
  logic [N-1:0] exp_ov, exp_pr;
  logic [11:0] exp_od [N];
  bit pend_v;
  logic [11:0] pend_raw;

  moving_avg_filter #(.DATA_W(12), .LOG2_DEPTH(3), .SIGNED_MODE(0), .ROUND(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .primed(pr[0]));
  moving_avg_filter #(.DATA_W(12), .LOG2_DEPTH(3), .SIGNED_MODE(1), .ROUND(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .primed(pr[1]));
  moving_avg_filter #(.DATA_W(12), .LOG2_DEPTH(3), .SIGNED_MODE(0), .ROUND(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .primed(pr[2]));
  moving_avg_filter #(.DATA_W(12), .LOG2_DEPTH(3), .SIGNED_MODE(1), .ROUND(1)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[3]), .out_data(od[3]), .primed(pr[3]));
  moving_avg_filter #(.DATA_W(12), .LOG2_DEPTH(0), .SIGNED_MODE(0), .ROUND(0)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[4]), .out_data(od[4]), .primed(pr[4]));

  always #5 clk = ~clk;

  function automatic int lg_of(input int i);
    return (i == 4) ? 0 : 3;
  endfunction
  function automatic bit sg_of(input int i);
    return (i == 1 || i == 3);
  endfunction
  function automatic bit rd_of(input int i);
    return (i == 2 || i == 3);
  endfunction

  function automatic int cond_f(input int i, input logic [11:0] d);
    if (sg_of(i)) return d[11] ? int'(d) - 4096 : int'(d);
    return d[11] ? 0 : int'(d);
  endfunction

  // Floor-divided window mean (zero-filled history), clamped to the max positive code.
  function automatic logic [11:0] avg_f(input int i);
    int s, depth, n, q;
    logic [31:0] qv;
    s = 0;
    for (int k = 0; k < win[i].size(); k++) s += win[i][k];
    depth = 1 << lg_of(i);
    n = s + ((rd_of(i) && depth > 1) ? depth / 2 : 0);
    q = n / depth;
    if ((n % depth) != 0 && n < 0) q--;
    if (q > 2047) q = 2047;
    qv = q;
    return qv[11:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      win[i].delete();
      cnt[i] = 0;
      exp_od[i] = '0;
    end
    exp_ov = '0;
    exp_pr = '0;
    pend_v = 1'b0;
    pend_raw = '0;
  endtask

  task automatic cycle(input bit v, input logic [11:0] d, input bit c);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      exp_ov[i] = 1'b0;
      if (c) begin
        win[i].delete();
        cnt[i] = 0;
        exp_od[i] = '0;
      end else if (pend_v) begin
        win[i].push_back(cond_f(i, pend_raw));
        if (win[i].size() > (1 << lg_of(i))) void'(win[i].pop_front());
        if (cnt[i] < (1 << lg_of(i))) cnt[i]++;
        exp_od[i] = avg_f(i);
        exp_ov[i] = 1'b1;
      end
      exp_pr[i] = (cnt[i] >= (1 << lg_of(i)));
    end
    pend_v   = v && !c;
    pend_raw = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    model_clear();
    #2;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if ({ov[i], pr[i], od[i]} !== 14'd0) begin
        n_err++;
        $display("FAIL reset u%0d: got ov=%b pr=%b od=%h want all 0", i, ov[i], pr[i], od[i]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int k;
    logic [11:0] want;
    k = 0;
    for (int s = 0; s < 12; s++) begin
      cycle(s < 9, 12'd1000, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
          n_err++;
          $display("FAIL ramp u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
        end
      end
      if (ov[0]) begin
        k++;
        want = (k <= 8) ? 12'(125 * k) : 12'd1000;
        n_cmp++;
        if (od[0] !== want || pr[0] !== (k >= 8)) begin
          n_err++;
          $display("FAIL ramp_const #%0d: got %0d pr=%b want %0d pr=%b", k, od[0], pr[0], want, (k >= 8));
        end
      end
    end
    n_cmp++;
    if (k != 9) begin
      n_err++;
      $display("FAIL ramp_pulses: got %0d want 9", k);
    end
  endtask

  task automatic test_clamp();
    cycle(1'b0, 12'd0, 1'b1);
    for (int s = 0; s < 12; s++) begin
      cycle(s < 9, (s < 8) ? 12'd800 : 12'h900, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
          n_err++;
          $display("FAIL clamp u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
        end
      end
    end
    n_cmp++;
    if (od[0] !== 12'd700) begin
      n_err++;
      $display("FAIL clamp_const: got %0d want 700", od[0]);
    end
  endtask

  task automatic test_signed();
    cycle(1'b0, 12'd0, 1'b1);
    for (int s = 0; s < 20; s++) begin
      cycle((s % 10) < 8, (s < 10) ? 12'hFF8 : 12'd8, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
          n_err++;
          $display("FAIL signed u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
        end
      end
      if (s == 9 || s == 19) begin
        n_cmp++;
        if (od[1] !== ((s == 9) ? 12'hFF8 : 12'd8)) begin
          n_err++;
          $display("FAIL signed_const s%0d: got %h want %h", s, od[1], (s == 9) ? 12'hFF8 : 12'd8);
        end
      end
    end
  endtask

  task automatic test_round();
    logic [11:0] seq [8];
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 8; k++) seq[k] = (k >= 6) ? 12'd0 : (pass == 0 ? 12'd2 : 12'hFFE);
      cycle(1'b0, 12'd0, 1'b1);
      for (int s = 0; s < 10; s++) begin
        cycle(s < 8, (s < 8) ? seq[s] : 12'd0, 1'b0);
        for (int i = 0; i < N; i++) begin
          n_cmp++;
          if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
            n_err++;
            $display("FAIL round u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
          end
        end
      end
      n_cmp++;
      if (pass == 0 && (od[0] !== 12'd1 || od[2] !== 12'd2)) begin
        n_err++;
        $display("FAIL round_unsigned: got trunc=%0d rnd=%0d want 1 2", od[0], od[2]);
      end
      if (pass == 1 && (od[1] !== 12'hFFE || od[3] !== 12'hFFF)) begin
        n_err++;
        $display("FAIL round_signed: got trunc=%h rnd=%h want ffe fff", od[1], od[3]);
      end
    end
  endtask

  task automatic test_gaps();
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int acc, pulses;
    bit v;
    acc = 0; pulses = 0;
    cycle(1'b0, 12'd0, 1'b1);
    for (int s = 0; s < 50; s++) begin
      v = (s < 7) ? pat[s] : ((s < 47) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (v) acc++;
      cycle(v, 12'($urandom), 1'b0);
      if (ov[0]) pulses++;
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
          n_err++;
          $display("FAIL gaps u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
        end
      end
    end
    n_cmp++;
    if (pulses != acc) begin
      n_err++;
      $display("FAIL gaps_pulses: got %0d want %0d", pulses, acc);
    end
  endtask

  task automatic test_clr();
    cycle(1'b0, 12'd0, 1'b1);
    for (int s = 0; s < 9; s++) begin
      if (s < 5) cycle(1'b1, 12'($urandom), 1'b0);
      else if (s == 5) cycle(1'b1, 12'($urandom), 1'b1);
      else if (s == 6) cycle(1'b1, 12'd800, 1'b0);
      else cycle(1'b0, 12'd0, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
          n_err++;
          $display("FAIL clr u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
        end
      end
      if (s == 5) begin
        n_cmp++;
        if (pr !== '0 || ov !== '0) begin
          n_err++;
          $display("FAIL clr_primed: got pr=%b ov=%b want 0 0", pr, ov);
        end
      end
      if (s == 7) begin
        n_cmp++;
        if (ov[0] !== 1'b1 || od[0] !== 12'd100) begin
          n_err++;
          $display("FAIL clr_first: got ov=%b od=%0d want 1 100", ov[0], od[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 4; s++) cycle(1'b1, 12'($urandom_range(0, 2047)), 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if ({ov[i], pr[i], od[i]} !== 14'd0) begin
        n_err++;
        $display("FAIL reset_mid u%0d: got ov=%b pr=%b od=%h want all 0", i, ov[i], pr[i], od[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 12'd0, 1'b0);
      n_cmp++;
      if (ov !== '0 || pr !== '0) begin
        n_err++;
        $display("FAIL reset_mid_idle: got ov=%b pr=%b want 0 0", ov, pr);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      cycle(1'($urandom_range(0, 3) != 0), 12'($urandom), ($urandom_range(0, 39) == 0));
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({ov[i], pr[i], od[i]} !== {exp_ov[i], exp_pr[i], exp_od[i]}) begin
          n_err++;
          $display("FAIL random u%0d: got %b/%b/%h want %b/%b/%h", i, ov[i], pr[i], od[i], exp_ov[i], exp_pr[i], exp_od[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp();
    test_signed();
    test_round();
    test_gaps();
    test_clr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
